mmio_queue: RTL and testbench
=============================

MMIO_QUEUE -- requirements
Module: mmio_queue

Interface
REQ-001 Parameter BASE, default 16'h1700, word address of the DATA register; STATUS is BASE+1, CTRL is BASE+2.
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of queue depth; depth = 256 entries of `DATA_W bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a  input  16  word address from CPU data bus (aluresult[17:2]).
REQ-006 wd  input  `DATA_W  CPU store data (writedata).
REQ-007 we  input  1  CPU store strobe (memwrite), sampled at rising edge.
REQ-008 re  input  1  CPU load strobe, high for the whole load cycle, sampled at rising edge.
REQ-009 rd  output  `DATA_W  read data, combinational from a and state.
REQ-010 sel  output  1  high when a is in BASE..BASE+2; system muxes rd over dmem rd.
REQ-011 nempty  output  1  registered level, high while count != 0.

Function
REQ-012 Storage: 256 x `DATA_W array, head pointer, tail pointer (DEPTH_LOG2 bits each, wrap modulo depth), count (DEPTH_LOG2+1 bits, 0..256).
REQ-013 Push: we && a==BASE && count<256 -> mem[tail]<=wd, tail<=tail+1, count<=count+1 at the same edge.
REQ-014 Push while full (count==256): store dropped, no pointer or count change.
REQ-015 Pop: re && a==BASE && count!=0 -> head<=head+1, count<=count-1 at the edge ending the load cycle.
REQ-016 Pop while empty: no state change.
REQ-017 rd for a==BASE: mem[head] when count!=0, 32'h0 when empty; valid in the same cycle as re (zero-latency read, pop takes effect next cycle).
REQ-018 rd for a==BASE+1 (STATUS): bit0 empty, bit1 full, bits[10:2] count, bits[29:11] zero, bits[31:30] per REQ-027.
REQ-019 rd for a==BASE+2 (CTRL): 32'h0.
REQ-020 rd when sel is low: 32'h0.
REQ-021 Write CTRL with wd[0]=1: head, tail, count <= 0 at the edge; array contents not cleared.
REQ-022 Writes to STATUS, and reads with re to CTRL or STATUS, have no side effect.
REQ-023 Wrap-around: tail/head go from 255 to 0; count alone distinguishes full from empty when head==tail.
REQ-024 we and re both high in one cycle: we takes priority and re is ignored.
REQ-025 nempty updates at the same edge as count; high while count != 0 after that edge.

Reset
REQ-026 rst_n low asynchronously forces head=0, tail=0, count=0, nempty=0, error flags=0, immediately and mid-operation; array contents undefined; rd/sel stay combinational.

Configuration
REQ-027 Macro QUEUE_ERRFLAG_EN defined: sticky ovf flag (STATUS bit31) set by a push dropped per REQ-014, sticky udf flag (bit30) set by a pop while empty per REQ-016; both cleared by CTRL write with wd[1]=1 and by reset.
REQ-028 Macro QUEUE_ERRFLAG_EN undefined: no flag registers; STATUS bits[31:30] read 0; wd[1] ignored.

Verification
REQ-029 Reset, then 3 stores of 11,22,33 to BASE -> STATUS reads 32'h0000000C (count 3); nempty=1; three loads from BASE return 11,22,33; STATUS then reads 32'h00000001.
REQ-030 256 stores of i to BASE -> STATUS reads 32'h00000402 (full, count 256); 257th store of 32'hDEAD dropped; 256 loads return 0..255 in order; with QUEUE_ERRFLAG_EN STATUS bit31=1 after the 257th store.
REQ-031 Push 200, pop 200, push 100, pop 100 -> values intact across pointer wrap, head==tail==44, empty.
REQ-032 Load from BASE while empty -> rd=32'h0, count stays 0; with QUEUE_ERRFLAG_EN bit30=1, then CTRL write 32'h2 clears it.
REQ-033 Push 5 entries, drop rst_n for 1ns between edges -> count, nempty, STATUS count field go to 0 without a clock edge; 5 entries then pushed and read back correctly.
REQ-034 Push 4 entries, store 32'h1 to BASE+2 -> STATUS reads 32'h00000001; store to a=BASE+3 -> sel=0, no state change.

Source files
------------

// File: rtl/mmio_queue.sv
// Memory-mapped FIFO for a CPU data bus: DATA pushes on store / pops on load, STATUS and CTRL beside it.
// Optional sticky overflow/underflow flags in STATUS[31:30] are built when QUEUE_ERRFLAG_EN is defined.
`ifndef DATA_W
`define DATA_W 32
`endif

module mmio_queue #(
    parameter logic [15:0] BASE       = 16'h1700,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic [`DATA_W-1:0] wd,
    input  logic               we,
    input  logic               re,
    output logic [`DATA_W-1:0] rd,
    output logic               sel,
    output logic               nempty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [`DATA_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head, tail, head_n, tail_n;
    logic [DEPTH_LOG2:0]   count, count_n;
    logic                  hit_data, hit_stat, hit_ctrl;
    logic                  empty, full, push, pop, clr_ptr;
    logic                  ovf, udf;
    logic [31:0]           status;

    assign hit_data = (a == BASE);
    assign hit_stat = (a == BASE + 16'd1);
    assign hit_ctrl = (a == BASE + 16'd2);
    assign sel      = hit_data | hit_stat | hit_ctrl;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Strobes are single-cycle requests with no back-pressure: a store wins over a
    // load in the same cycle, and a load's pop lands on the edge that ends it.
    assign push    = we && hit_data && !full;
    assign pop     = !we && re && hit_data && !empty;
    assign clr_ptr = we && hit_ctrl && wd[0];

    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (clr_ptr) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else if (push) begin
            tail_n  = tail + 1'b1;
            count_n = count + 1'b1;
        end else if (pop) begin
            head_n  = head + 1'b1;
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            nempty <= 1'b0;
        end else begin
            head   <= head_n;
            tail   <= tail_n;
            count  <= count_n;
            nempty <= (count_n != '0);
        end
    end

    // Storage carries no reset; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wd;
        end
    end

`ifdef QUEUE_ERRFLAG_EN
    logic drop, underrun, clr_flags;

    assign drop      = we && hit_data && full;
    assign underrun  = !we && re && hit_data && empty;
    assign clr_flags = we && hit_ctrl && wd[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (clr_flags) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (drop)     ovf <= 1'b1;
                if (underrun) udf <= 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    always_comb begin
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[10:2] = 9'(count);
        status[31]   = ovf;
        status[30]   = udf;
    end

    always_comb begin
        rd = '0;
        if (hit_data && !empty) begin
            rd = mem[head];
        end else if (hit_stat) begin
            rd = `DATA_W'(status);
        end
    end

endmodule

// File: tb/tb_mmio_queue.sv
// Bench for mmio_queue: directed scenarios then random bus traffic, every load checked
// by a monitor against expectations queued from a queue-based reference model.
`timescale 1ns/100ps

module tb_mmio_queue;

    localparam logic [15:0] BASE   = 16'h1700;
    localparam logic [15:0] STAT   = BASE + 16'd1;
    localparam logic [15:0] CTRL   = BASE + 16'd2;
    localparam int          DEPTH  = 256;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        sel;
    logic        nempty;

    mmio_queue #(.BASE(BASE), .DEPTH_LOG2(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .wd     (wd),
        .we     (we),
        .re     (re),
        .rd     (rd),
        .sel    (sel),
        .nempty (nempty)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model_q[$];
    bit          model_ovf;
    bit          model_udf;
    int          n_cmp;
    int          n_bad;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (model_q.size() == 0);
        s[1]    = (model_q.size() == DEPTH);
        s[10:2] = 9'(model_q.size());
`ifdef QUEUE_ERRFLAG_EN
        s[31]   = model_ovf;
        s[30]   = model_udf;
`endif
        return s;
    endfunction

    function automatic logic [31:0] model_rd(logic [15:0] addr);
        if (addr == BASE) return (model_q.size() != 0) ? model_q[0] : 32'h0;
        if (addr == STAT) return model_status();
        return 32'h0;
    endfunction

    function automatic void model_step(logic [15:0] addr, logic [31:0] data, bit w, bit r);
        if (w) begin
            if (addr == BASE) begin
                if (model_q.size() < DEPTH) model_q.push_back(data);
                else model_ovf = 1'b1;
            end else if (addr == CTRL) begin
                if (data[0]) model_q.delete();
                if (data[1]) begin
                    model_ovf = 1'b0;
                    model_udf = 1'b0;
                end
            end
        end else if (r && addr == BASE) begin
            if (model_q.size() != 0) void'(model_q.pop_front());
            else model_udf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_udf = 1'b0;
    endfunction

    // ---------------- monitor: rd during loads, sel always ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            int off;
            off = int'(a) - int'(BASE);
            check("sel", {31'b0, sel}, {31'b0, (off >= 0 && off <= 2)});
            if (re) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 32'h1, 32'h0);
                end else begin
                    check("rd_load", rd, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic op(input logic [15:0] addr, input logic [31:0] data, input bit w, input bit r);
        a  = addr;
        wd = data;
        we = w;
        re = r;
        if (r) exp_q.push_back(model_rd(addr));
        model_step(addr, data, w, r);
        @(posedge clk);
        #1;
        check("nempty", {31'b0, nempty}, {31'b0, (model_q.size() != 0)});
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic store(input logic [15:0] addr, input logic [31:0] data);
        op(addr, data, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [15:0] addr);
        op(addr, 32'h0, 1'b0, 1'b1);
    endtask

    // Combinational look at rd without a strobe, against a literal expectation.
    task automatic peek(input logic [15:0] addr, input logic [31:0] exp, input string name);
        a  = addr;
        we = 1'b0;
        re = 1'b0;
        #1;
        check(name, rd, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst_n = 1'b0;
        a = '0;
        wd = '0;
        we = 1'b0;
        re = 1'b0;
        #12;
        check("reset_nempty", {31'b0, nempty}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        peek(STAT, 32'h0000_0001, "reset_status");

        // three stores, three loads
        store(BASE, 32'd11);
        store(BASE, 32'd22);
        store(BASE, 32'd33);
        peek(STAT, 32'h0000_000C, "status_cnt3");
        check("nempty_cnt3", {31'b0, nempty}, 32'h1);
        for (int i = 0; i < 3; i++) load(BASE);
        peek(STAT, 32'h0000_0001, "status_drained");

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) store(BASE, i);
        peek(STAT, 32'h0000_0402, "status_full");
        store(BASE, 32'hDEAD);
`ifdef QUEUE_ERRFLAG_EN
        peek(STAT, 32'h8000_0402, "status_full_ovf");
`else
        peek(STAT, 32'h0000_0402, "status_full_noflag");
`endif
        for (int i = 0; i < DEPTH; i++) load(BASE);
        store(CTRL, 32'h2);
        peek(STAT, 32'h0000_0001, "status_after_drain");

        // pointer wrap
        for (int i = 0; i < 200; i++) store(BASE, 32'h1000 + i);
        for (int i = 0; i < 200; i++) load(BASE);
        for (int i = 0; i < 100; i++) store(BASE, 32'h2000 + i);
        for (int i = 0; i < 100; i++) load(BASE);
        peek(STAT, 32'h0000_0001, "status_wrap_empty");

        // load while empty
        load(BASE);
`ifdef QUEUE_ERRFLAG_EN
        peek(STAT, 32'h4000_0001, "status_udf");
`else
        peek(STAT, 32'h0000_0001, "status_udf_noflag");
`endif
        store(CTRL, 32'h2);
        peek(STAT, 32'h0000_0001, "status_udf_cleared");

        // asynchronous reset between edges
        for (int i = 0; i < 5; i++) store(BASE, 32'hA0 + i);
        a = STAT;
        #1;
        rst_n = 1'b0;
        #0.5;
        check("async_nempty", {31'b0, nempty}, 32'h0);
        check("async_status", rd, 32'h0000_0001);
        #0.5;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) store(BASE, 32'hB0 + i);
        for (int i = 0; i < 5; i++) load(BASE);

        // CTRL clear and out-of-range store
        for (int i = 0; i < 4; i++) store(BASE, 32'hC0 + i);
        store(CTRL, 32'h1);
        peek(STAT, 32'h0000_0001, "status_ctrl_clr");
        store(BASE, 32'h77);
        store(BASE + 16'd3, 32'hFFFF_FFFF);
        a = BASE + 16'd3;
        #1;
        check("sel_outside", {31'b0, sel}, 32'h0);
        check("rd_outside", rd, 32'h0);
        peek(STAT, 32'h0000_0004, "status_outside_nochg");
        store(STAT, 32'hFFFF_FFFF);
        load(CTRL);
        load(STAT);
        load(BASE);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int pick;
            pick = $urandom_range(0, 99);
            if (pick < 45)      store(BASE, $urandom);
            else if (pick < 80) load(BASE);
            else if (pick < 85) load(STAT);
            else if (pick < 87) load(CTRL);
            else if (pick < 89) store(STAT, $urandom);
            else if (pick < 92) op(BASE, $urandom, 1'b1, 1'b1);
            else if (pick < 95) load(BASE + 16'($urandom_range(3, 40)));
            else if (pick < 96) store(CTRL, 32'($urandom_range(0, 3)));
            else                store(BASE - 16'd1, $urandom);
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
